// File: rtl/trim_pkg.sv
// trim_pkg: shared state encoding and defaults for the trim receiver and generator
package trim_pkg;
    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
    localparam int NBITS_DEF = 12;
    localparam int IDLE_CYCLES_DEF = 50000000;
endpackage

// File: rtl/trim_sync.sv
// trim_sync: two-flop synchronizer into CLK50 with falling-edge detect
module trim_sync (
    input  logic CLK50,
    input  logic RST,
    input  logic d,
    output logic q,
    output logic fall
);
    logic meta, prev;
    always_ff @(posedge CLK50 or posedge RST)
        if (RST) {meta, q, prev} <= '0;
        else     {meta, q, prev} <= {d, meta, q};
    assign fall = prev & ~q;
endmodule

// File: rtl/trim_rx.sv
// trim_rx: receives LSB-first serial trim frames clocked by a gated ENCLK, closed by ENCLK idle time
module trim_rx import trim_pkg::*; #(
    parameter int NBITS = NBITS_DEF,
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF
) (
    input  logic             CLK50,
    input  logic             RST,
    input  logic             ENCLK,
    input  logic             DIN,
    output logic [NBITS-1:0] TRIM,
    output logic             TRIM_VALID,
    output logic             FRAME_ERR,
    output logic             BUSY
);
    localparam int BW = $clog2(NBITS + 2);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    state_t state;
    logic [NBITS-1:0] sr;
    logic [BW-1:0] cnt;
    logic [IW-1:0] idle;
    logic clk_s, clk_fall, din_s, unused_din_fall;
    trim_sync u_clk (.CLK50(CLK50), .RST(RST), .d(ENCLK), .q(clk_s), .fall(clk_fall));
    trim_sync u_din (.CLK50(CLK50), .RST(RST), .d(DIN), .q(din_s), .fall(unused_din_fall));
    // idle time only accumulates (and can close the frame) while ENCLK sits low
    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            TRIM <= '0;
            TRIM_VALID <= 1'b0;
            FRAME_ERR <= 1'b0;
            BUSY <= 1'b0;
            sr <= '0;
            cnt <= '0;
            idle <= '0;
        end else begin
            TRIM_VALID <= 1'b0;
            FRAME_ERR <= 1'b0;
            case (state)
                IDLE: if (clk_fall) begin
                    sr <= {din_s, sr[NBITS-1:1]};
                    cnt <= BW'(1);
                    idle <= '0;
                    BUSY <= 1'b1;
                    state <= RECV;
                end
                RECV: if (clk_fall) begin
                    sr <= {din_s, sr[NBITS-1:1]};
                    cnt <= (cnt == BW'(NBITS + 1)) ? cnt : cnt + 1'b1;
                    idle <= '0;
                end else if (!clk_s) begin
                    if (idle == IW'(IDLE_CYCLES - 1)) begin
                        BUSY <= 1'b0;
                        state <= CHECK;
                    end else idle <= idle + 1'b1;
                end
                CHECK: begin
                    if (cnt == BW'(NBITS)) begin
                        TRIM <= sr;
                        TRIM_VALID <= 1'b1;
                    end else FRAME_ERR <= 1'b1;
                    sr <= '0;
                    cnt <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
